complex_addsub_pipe: RTL
========================

Name: complex_addsub_pipe

Overview:
- Parametrised, pipelined complex adder/subtractor for the FFT datapath.
- Operands are packed {real, imag} words. Each component is added or subtracted independently, and the operation is selected per transaction.
- Includes a valid/ready handshake with full-pipeline stall, per-component carry and signed-overflow flags, and a sticky overflow status.
- Sits between butterfly multiplier outputs and stage memory, and is the generalised replacement for the fixed 32-bit complex adder.

Parameters:
- DW, 16, width of each real/imag component; legal values 4 to 32.
- LAT, 2, pipeline latency in clock cycles; legal values 1 to 4.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block accepts a transaction this cycle.
- in_sub  input  1  0 = A+B, 1 = A-B (applies to both components).
- in_a  input  2*DW  operand A, packed {real[2*DW-1:DW], imag[DW-1:0]}.
- in_b  input  2*DW  operand B, same packing.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_r  output  2*DW  result, packed {real, imag}.
- out_cout  output  2  {carry_real, carry_imag}.
- out_ovf  output  2  {ovf_real, ovf_imag}, signed two's-complement overflow.
- ovf_sticky  output  1  set when any accepted result has an overflow bit.
- ovf_clr  input  1  clears ovf_sticky.

Behaviour:
- Reset (rst=1 at clk edge):
  - All stage valid bits cleared.
  - out_valid=0, out_r=0, out_cout=0, out_ovf=0, ovf_sticky=0.
  - in_ready=1 in the cycle after reset is released.
  - Reset mid-operation discards all in-flight transactions; no partial output appears.
- Advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv, combinational.
  - When adv=0 the whole pipeline holds; every stage register and valid bit is unchanged.
- Accept: a transaction is accepted when in_valid & in_ready.
- Latency:
  - An accepted transaction appears at out_valid exactly LAT cycles later, assuming no stall.
  - Each stall cycle adds one cycle.
  - Order is preserved and there are no bubbles inserted by the block.
  - Throughput is 1 transaction per cycle when out_ready=1.
- Arithmetic per component, computed on DW+1 bits:
  - Add: {c, s} = a + b.
  - Sub: {c, s} = a + ~b + 1. Here c=1 means no borrow (a >= b unsigned).
  - ovf = signed overflow:
    - Add: sign(a)==sign(b) and sign(s)!=sign(a).
    - Sub: sign(a)!=sign(b) and sign(s)!=sign(a).
  - Real and imag components never share a carry.
- Pipeline split:
  - Stage 1 registers the operands and in_sub.
  - Sum/flags are computed in stage 1 output logic.
  - Remaining LAT-1 stages are pure delay registers.
  - For LAT=1, the result register is the only register.
- Holding invalid slots: out_r, out_cout and out_ovf hold their last values while out_valid=0.
- ovf_sticky:
  - Set when a transaction leaves the block (out_valid & out_ready) with out_ovf != 0.
  - ovf_clr=1 clears it.
  - If set and clear occur in the same cycle, set wins.
- Simultaneous accept and output in the same cycle is legal and is the steady-state condition.
- Boundaries:
  - Full pipeline with out_ready=0: in_ready=0 and nothing is lost.
  - Releasing out_ready drains one result per cycle.

Optional Feature:
- Macro: COMPLEX_ADDSUB_SAT_EN.
- Defined:
  - A component with ovf=1 is clamped to the most-positive value 0x7FF..F if the sign of a was 0, else to the most-negative value 0x800..0.
  - out_ovf still reports 1, and out_cout is unchanged (raw carry).
  - Clamping occurs in the same stage as the add; latency is unchanged.
- Not defined: wrap-around two's-complement result; no clamp logic is synthesised.

Test Plan:
- DW=16, LAT=2, add, a={0x0003,0xFFFF}, b={0x0004,0x0001}:
  - out_r={0x0007,0x0000}, out_cout=2'b01, out_ovf=2'b00, out_valid exactly 2 cycles after accept.
- Sub, a={0x0000,0x0005}, b={0x0001,0x0005}:
  - out_r={0xFFFF,0x0000}, out_cout=2'b01, out_ovf=2'b00.
- Add, a={0x7FFF,0x8000}, b={0x0001,0xFFFF}:
  - Without SAT: out_r={0x8000,0x7FFF}, out_ovf=2'b11, ovf_sticky=1 the next cycle.
  - With COUT_ADDSUB_SAT_EN renamed correctly as COMPLEX_ADDSUB_SAT_EN: out_r={0x7FFF,0x8000}.
  - Then ovf_clr=1 -> ovf_sticky=0.
- Back-to-back stream of 8 add transactions with out_ready held 0 from cycle 3 for 5 cycles:
  - in_ready falls once the pipeline is full.
  - All 8 results emerge in order with no duplicates or drops.
- Two transactions in flight, rst=1 for one cycle:
  - out_valid=0 the next cycle, and no stale result appears afterwards.
  - A fresh transaction then completes with latency LAT.
- LAT=1 and LAT=4 builds with continuous valid and out_ready=1:
  - One result per cycle, first result at cycle LAT after the first accept.

Source files
------------

// File: rtl/complex_addsub_pipe_if.sv
// Operand/result handshake bundle for complex_addsub_pipe.
// The master drives operands and out_ready; the slave is the pipeline.
interface complex_addsub_pipe_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sub;
  logic [2*DW-1:0] in_a;
  logic [2*DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [2*DW-1:0] out_r;
  logic [1:0]    out_cout;
  logic [1:0]    out_ovf;

  modport master (
    output in_valid, in_sub, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_r, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_sub, in_a, in_b, out_ready,
    output in_ready, out_valid, out_r, out_cout, out_ovf
  );
endinterface

// File: rtl/complex_addsub_pipe.sv
// Pipelined complex add/sub with stall, carry/overflow flags, sticky ovf.
// Define COMPLEX_ADDSUB_SAT_EN to clamp overflowed components.
module complex_addsub_pipe #(
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  complex_addsub_pipe_if.slave bus,
  output logic ovf_sticky,
  input  logic ovf_clr
);
  localparam int RW = 2*DW + 4;

  logic          adv;
  logic          vout_q;
  logic [RW-1:0] res_q;
  logic          sticky_q;
  logic          sticky_d;

  // returns {carry, ovf, sum}
  function automatic logic [DW+1:0] comp(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic          sub
  );
    logic [DW-1:0] bx;
    logic [DW:0]   t;
    logic [DW-1:0] s;
    logic          ov;
    bx = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bx} + {{DW{1'b0}}, sub};
    s  = t[DW-1:0];
    ov = (a[DW-1] == bx[DW-1]) && (s[DW-1] != a[DW-1]);
`ifdef COMPLEX_ADDSUB_SAT_EN
    if (ov)
      s = a[DW-1] ? {1'b1, {(DW-1){1'b0}}}
                  : {1'b0, {(DW-1){1'b1}}};
`endif
    return {t[DW], ov, s};
  endfunction

  // packed as {r_real, r_imag, c_real, c_imag, o_real, o_imag}
  function automatic logic [RW-1:0] calc(
    input logic [2*DW-1:0] a,
    input logic [2*DW-1:0] b,
    input logic            sub
  );
    logic [DW+1:0] re;
    logic [DW+1:0] im;
    re = comp(a[2*DW-1:DW], b[2*DW-1:DW], sub);
    im = comp(a[DW-1:0], b[DW-1:0], sub);
    return {re[DW-1:0], im[DW-1:0],
            re[DW+1], im[DW+1], re[DW], im[DW]};
  endfunction

  assign adv           = bus.out_ready | ~vout_q;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vout_q;
  assign bus.out_r     = res_q[RW-1:4];
  assign bus.out_cout  = res_q[3:2];
  assign bus.out_ovf   = res_q[1:0];

  generate
    if (LAT == 1) begin : g_l1
      always_ff @(posedge clk) begin
        if (rst) begin
          vout_q <= 1'b0;
          res_q  <= '0;
        end else if (adv) begin
          vout_q <= bus.in_valid;
          if (bus.in_valid)
            res_q <= calc(bus.in_a, bus.in_b, bus.in_sub);
        end
      end
    end else begin : g_ln
      logic [2*DW-1:0] a_q;
      logic [2*DW-1:0] b_q;
      logic            sub_q;
      logic            v1_q;
      logic [RW-1:0]   sum_d;
      logic [RW-1:0]   dly_q [LAT-1];
      logic [LAT-2:0]  dv_q;

      assign sum_d  = calc(a_q, b_q, sub_q);
      assign res_q  = dly_q[LAT-2];
      assign vout_q = dv_q[LAT-2];

      // data regs load only with valid data so outputs hold across bubbles
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
          v1_q  <= 1'b0;
          dv_q  <= '0;
          for (int k = 0; k < LAT-1; k++)
            dly_q[k] <= '0;
        end else if (adv) begin
          v1_q <= bus.in_valid;
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            sub_q <= bus.in_sub;
          end
          dv_q[0] <= v1_q;
          if (v1_q)
            dly_q[0] <= sum_d;
          for (int k = 1; k < LAT-1; k++) begin
            dv_q[k] <= dv_q[k-1];
            if (dv_q[k-1])
              dly_q[k] <= dly_q[k-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    sticky_d = sticky_q;
    if (vout_q & bus.out_ready & (|res_q[1:0]))
      sticky_d = 1'b1;
    else if (ovf_clr)
      sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
endmodule
